line_memory_responder: RTL and testbench

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

---
 rtl/line_memory_responder.sv | 101 ++++++++++
 tb/tb_line_memory_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Line-oriented memory responder: accepts one held read/write request, answers
// after LATENCY cycles with a one-cycle mem_ready strobe, then waits for release.
module line_memory_responder #(
   parameter int LATENCY   = 4,
   parameter int ADDR_BITS = 6
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   // BUSY occupies LATENCY-1 cycles, so the counter starts at LATENCY-2.
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   wr_q, wr_d;
   logic [127:0]           wdata_q, wdata_d;
   logic [127:0]           rdata_q, rdata_d;
   logic                   ready_q, ready_d;
   logic                   mem_we;
   logic [127:0]           mem_q [DEPTH];

   logic unused_addr_bits;
   assign unused_addr_bits = ^mem_addr[27:ADDR_BITS];

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               addr_d  = mem_addr[ADDR_BITS-1:0];
               wr_d    = mem_write;
               wdata_d = mem_wdata;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = RELEASE;
         RELEASE: if (!mem_read && !mem_write) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are computed from the state being entered.
   always_comb begin
      ready_d = (state_d == RESP);
      rdata_d = rdata_q;
      if (state_d == RESP && !wr_d) rdata_d = mem_q[addr_d];
      mem_we  = (state_q == RESP) && wr_q;
   end

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: LATENCY=4 and LATENCY=1 instances,
// expected responses queued at request time and compared at mem_ready.
module tb_line_memory_responder;

   typedef struct {
      int           lat;
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         proc_reset = 1'b1;
   logic         rd_r    [2];
   logic         wr_r    [2];
   logic [27:0]  addr_r  [2];
   logic [127:0] wd_r    [2];
   logic [127:0] rdata_w [2];
   logic         ready_w [2];

   int           lat [2] = '{4, 1};
   logic [127:0] model [2][64];
   logic [127:0] last  [2];
   exp_t         sbq[$];
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   line_memory_responder #(.LATENCY(4), .ADDR_BITS(6)) dut4 (
      .clk(clk), .proc_reset(proc_reset),
      .mem_read(rd_r[0]), .mem_write(wr_r[0]), .mem_addr(addr_r[0]),
      .mem_wdata(wd_r[0]), .mem_rdata(rdata_w[0]), .mem_ready(ready_w[0]));

   line_memory_responder #(.LATENCY(1), .ADDR_BITS(6)) dut1 (
      .clk(clk), .proc_reset(proc_reset),
      .mem_read(rd_r[1]), .mem_write(wr_r[1]), .mem_addr(addr_r[1]),
      .mem_wdata(wd_r[1]), .mem_rdata(rdata_w[1]), .mem_ready(ready_w[1]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         last[d] = '0;
         for (int i = 0; i < 64; i++) model[d][i] = '0;
      end
   endtask

   // One access on DUT d; hold = cycles the request stays up after mem_ready.
   task automatic access(input int d, input bit wr, input bit rd_too, input logic [27:0] addr,
                         input logic [127:0] wd, input int hold, input string tag);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      rd_r[d] = !wr || rd_too;
      wr_r[d] = wr;
      addr_r[d] = addr;
      wd_r[d] = wd;
      e.lat = lat[d];
      if (wr) begin
         e.data = last[d];
         model[d][addr[5:0]] = wd;
      end else begin
         e.data = model[d][addr[5:0]];
         last[d] = e.data;
      end
      sbq.push_back(e);
      n = 0;
      while (n <= 40) begin
         @(negedge clk);
         if (n == 1) begin
            addr_r[d] = ~addr;
            wd_r[d]   = ~wd;
         end
         if (ready_w[d]) break;
         n++;
      end
      e = sbq.pop_front();
      check({tag, "_latency"}, 128'(n), 128'(e.lat));
      check({tag, "_rdata"}, rdata_w[d], e.data);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_held_no_ready"}, 128'(ready_w[d]), 128'd0);
      end
      @(posedge clk); #1;
      rd_r[d] = 1'b0;
      wr_r[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rd_r[d] = 1'b0; wr_r[d] = 1'b0; addr_r[d] = '0; wd_r[d] = '0;
      end
      clear_model();
      repeat (2) @(negedge clk);
      check("reset_ready4", 128'(ready_w[0]), 128'd0);
      check("reset_rdata4", rdata_w[0], 128'd0);
      check("reset_ready1", 128'(ready_w[1]), 128'd0);
      check("reset_rdata1", rdata_w[1], 128'd0);
      @(posedge clk); #1 proc_reset = 1'b0;

      access(0, 1'b0, 1'b0, 28'h0000005, '0, 0, "rd_line5");
      access(0, 1'b1, 1'b0, 28'h0000003, 128'h44444444_33333333_22222222_11111111, 0, "wr_line3");
      access(0, 1'b0, 1'b0, 28'h0000043, '0, 0, "rd_alias43");
      access(0, 1'b0, 1'b0, 28'h0000003, '0, 3, "rd_hold3");
      access(0, 1'b0, 1'b0, 28'h0000003, '0, 0, "rd_again");
      access(0, 1'b1, 1'b1, 28'h0000007, 128'hA5, 0, "rdwr_line7");
      access(0, 1'b0, 1'b0, 28'h0000007, '0, 0, "rd_line7");
      access(0, 1'b1, 1'b0, 28'hABCDE12, 128'hDEADBEEF_0BADF00D_CAFEF00D_12345678, 1, "wr_line12");
      access(0, 1'b0, 1'b0, 28'h0000052, '0, 0, "rd_alias52");

      // Reset in cycle 2 of a write to line 9 aborts it.
      @(posedge clk); #1;
      wr_r[0] = 1'b1; addr_r[0] = 28'h0000009; wd_r[0] = 128'h9999;
      @(posedge clk); @(posedge clk); #1;
      proc_reset = 1'b1;
      @(negedge clk);
      check("rst_abort_ready", 128'(ready_w[0]), 128'd0);
      @(posedge clk); #1;
      wr_r[0] = 1'b0;
      proc_reset = 1'b0;
      clear_model();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst_no_pulse", 128'(ready_w[0]), 128'd0);
      end
      access(0, 1'b0, 1'b0, 28'h0000009, '0, 0, "rd_line9_after_rst");
      access(0, 1'b0, 1'b0, 28'h0000003, '0, 0, "rd_line3_after_rst");

      access(1, 1'b1, 1'b0, 28'h0000002, 128'h0123_4567_89AB_CDEF, 0, "l1_wr_line2");
      access(1, 1'b0, 1'b0, 28'h0000002, '0, 2, "l1_rd_line2");
      access(1, 1'b0, 1'b0, 28'h0000005, '0, 0, "l1_rd_line5");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
